// File: rtl/rvx_core_bus_merger_pkg.sv
// rvx_core_bus_merger_pkg: shared types and defaults for the instruction/data bus merger
package rvx_core_bus_merger_pkg;
    typedef enum logic [1:0] {
        RVX_MERGER_IDLE         = 2'd0,
        RVX_MERGER_SERVE_FIRST  = 2'd1,
        RVX_MERGER_SERVE_SECOND = 2'd2
    } merger_state_t;
    localparam bit RVX_MERGER_DBUS_FIRST = 1'b1;
    typedef struct packed {
        logic [31:0] address;
        logic [31:0] wdata;
        logic [3:0]  wstrobe;
        logic        write;
    } dbus_req_t;
endpackage

// File: rtl/rvx_core_bus_merger_response_latch.sv
// rvx_bus_response_latch: per-master done flag plus held response data
module rvx_bus_response_latch (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        set,
    input  logic        clear,
    input  logic [31:0] data_in,
    output logic        done,
    output logic [31:0] data
);
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            done <= 1'b0;
            data <= '0;
        end else begin
            done <= set | (done & ~clear);
            if (set) data <= data_in;
        end
    end
endmodule

// File: rtl/rvx_core_bus_merger.sv
// rvx_core_bus_merger: serialises ibus/dbus onto one port and releases both responses together
module rvx_core_bus_merger
    import rvx_core_bus_merger_pkg::*;
#(
    parameter bit DBUS_FIRST = RVX_MERGER_DBUS_FIRST
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] ibus_address,
    input  logic        ibus_rrequest,
    output logic [31:0] ibus_rdata,
    output logic        ibus_rresponse,
    input  logic [31:0] dbus_address,
    input  logic        dbus_rrequest,
    input  logic        dbus_wrequest,
    input  logic [31:0] dbus_wdata,
    input  logic [3:0]  dbus_wstrobe,
    output logic [31:0] dbus_rdata,
    output logic        dbus_rresponse,
    output logic        dbus_wresponse,
    output logic [31:0] mem_address,
    output logic        mem_rrequest,
    output logic        mem_wrequest,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrobe,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rresponse,
    input  logic        mem_wresponse
);
    merger_state_t state, state_next;
    logic        need_i, need_d, first_d;
    logic [31:0] cap_iaddr, src_iaddr;
    dbus_req_t   cap_d, live_d, src_d;
    logic        new_i, new_d, new_first_d, cur_d, cur_write, resp_ok, other;
    logic        advance, rel, decision, issue, issue_d, rel_i, rel_d;
    logic        i_done, d_done;
    logic [31:0] i_data, d_data, i_hold, d_hold, i_value, d_value;

    assign live_d = '{address: dbus_address, wdata: dbus_wdata, wstrobe: dbus_wstrobe, write: dbus_wrequest};

    always_ff @(posedge clock) begin
        if (!reset_n) state <= RVX_MERGER_IDLE;
        else          state <= state_next;
    end

    // A release cycle doubles as the decision cycle for the core's next requests.
    always_comb begin
        new_i       = ibus_rrequest;
        new_d       = dbus_rrequest | dbus_wrequest;
        new_first_d = new_d & (DBUS_FIRST | ~new_i);
        cur_d       = (state == RVX_MERGER_SERVE_SECOND) ? ~first_d : first_d;
        cur_write   = cur_d & cap_d.write;
        resp_ok     = (state != RVX_MERGER_IDLE) & (cur_write ? mem_wresponse : mem_rresponse);
        other       = first_d ? need_i : need_d;
        advance     = (state == RVX_MERGER_SERVE_FIRST) & resp_ok & other;
        rel         = resp_ok & ~advance;
        decision    = (state == RVX_MERGER_IDLE) | rel;
        issue       = decision ? (new_i | new_d) : 1'b1;
        issue_d     = decision ? new_first_d :
                      ((state == RVX_MERGER_SERVE_SECOND) | advance) ? ~first_d : first_d;
        state_next  = decision ? ((new_i | new_d) ? RVX_MERGER_SERVE_FIRST : RVX_MERGER_IDLE) :
                      advance ? RVX_MERGER_SERVE_SECOND : state;
    end

    assign src_iaddr    = decision ? ibus_address : cap_iaddr;
    assign src_d        = decision ? live_d : cap_d;
    assign mem_address  = issue_d ? src_d.address : src_iaddr;
    assign mem_rrequest = reset_n & issue & ~(issue_d & src_d.write);
    assign mem_wrequest = reset_n & issue & issue_d & src_d.write;
    assign mem_wdata    = src_d.wdata;
    assign mem_wstrobe  = src_d.wstrobe;

    assign rel_i          = reset_n & rel & need_i;
    assign rel_d          = reset_n & rel & need_d;
    assign i_value        = i_done ? i_data : mem_rdata;
    assign d_value        = d_done ? d_data : mem_rdata;
    assign ibus_rresponse = rel_i;
    assign dbus_rresponse = rel_d & ~cap_d.write;
    assign dbus_wresponse = rel_d & cap_d.write;
    assign ibus_rdata     = rel_i ? i_value : i_hold;
    assign dbus_rdata     = dbus_rresponse ? d_value : d_hold;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            need_i    <= 1'b0;
            need_d    <= 1'b0;
            first_d   <= 1'b0;
            cap_iaddr <= '0;
            cap_d     <= '0;
            i_hold    <= '0;
            d_hold    <= '0;
        end else begin
            if (decision) begin
                need_i    <= new_i;
                need_d    <= new_d;
                first_d   <= new_first_d;
                cap_iaddr <= ibus_address;
                cap_d     <= live_d;
            end
            if (rel_i) i_hold <= i_value;
            if (dbus_rresponse) d_hold <= d_value;
        end
    end

    rvx_bus_response_latch ibus_latch (
        .clock   (clock),
        .reset_n (reset_n),
        .set     (advance & ~first_d),
        .clear   (rel),
        .data_in (mem_rdata),
        .done    (i_done),
        .data    (i_data)
    );

    rvx_bus_response_latch dbus_latch (
        .clock   (clock),
        .reset_n (reset_n),
        .set     (advance & first_d),
        .clear   (rel),
        .data_in (mem_rdata),
        .done    (d_done),
        .data    (d_data)
    );
endmodule

// File: tb/tb_rvx_core_bus_merger.sv
// tb_rvx_core_bus_merger: directed checks of the bus merger with both issue priorities
module tb_rvx_core_bus_merger;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] ibus_address, dbus_address, dbus_wdata, mem_rdata;
    logic        ibus_rrequest, dbus_rrequest, dbus_wrequest;
    logic [3:0]  dbus_wstrobe;
    logic        r1, w1, r0, w0;
    logic [31:0] ibus_rdata, dbus_rdata, mem_address, mem_wdata;
    logic        ibus_rresponse, dbus_rresponse, dbus_wresponse, mem_rrequest, mem_wrequest;
    logic [3:0]  mem_wstrobe;
    logic [31:0] ibus_rdata_b, dbus_rdata_b, mem_address_b, mem_wdata_b;
    logic        ibus_rresponse_b, dbus_rresponse_b, dbus_wresponse_b, mem_rrequest_b, mem_wrequest_b;
    logic [3:0]  mem_wstrobe_b;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clock = ~clock;

    rvx_core_bus_merger #(.DBUS_FIRST(1'b1)) dut (
        .clock(clock), .reset_n(reset_n),
        .ibus_address(ibus_address), .ibus_rrequest(ibus_rrequest),
        .ibus_rdata(ibus_rdata), .ibus_rresponse(ibus_rresponse),
        .dbus_address(dbus_address), .dbus_rrequest(dbus_rrequest), .dbus_wrequest(dbus_wrequest),
        .dbus_wdata(dbus_wdata), .dbus_wstrobe(dbus_wstrobe),
        .dbus_rdata(dbus_rdata), .dbus_rresponse(dbus_rresponse), .dbus_wresponse(dbus_wresponse),
        .mem_address(mem_address), .mem_rrequest(mem_rrequest), .mem_wrequest(mem_wrequest),
        .mem_wdata(mem_wdata), .mem_wstrobe(mem_wstrobe),
        .mem_rdata(mem_rdata), .mem_rresponse(r1), .mem_wresponse(w1)
    );

    rvx_core_bus_merger #(.DBUS_FIRST(1'b0)) dut_ibus_first (
        .clock(clock), .reset_n(reset_n),
        .ibus_address(ibus_address), .ibus_rrequest(ibus_rrequest),
        .ibus_rdata(ibus_rdata_b), .ibus_rresponse(ibus_rresponse_b),
        .dbus_address(dbus_address), .dbus_rrequest(dbus_rrequest), .dbus_wrequest(dbus_wrequest),
        .dbus_wdata(dbus_wdata), .dbus_wstrobe(dbus_wstrobe),
        .dbus_rdata(dbus_rdata_b), .dbus_rresponse(dbus_rresponse_b), .dbus_wresponse(dbus_wresponse_b),
        .mem_address(mem_address_b), .mem_rrequest(mem_rrequest_b), .mem_wrequest(mem_wrequest_b),
        .mem_wdata(mem_wdata_b), .mem_wstrobe(mem_wstrobe_b),
        .mem_rdata(mem_rdata), .mem_rresponse(r0), .mem_wresponse(w0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        ibus_rrequest = 1'b0;
        dbus_rrequest = 1'b0;
        dbus_wrequest = 1'b0;
        r1 = 1'b0;
        w1 = 1'b0;
        r0 = 1'b0;
        w0 = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        quiet();
        ibus_address = '0;
        dbus_address = '0;
        dbus_wdata   = '0;
        dbus_wstrobe = '0;
        mem_rdata    = '0;
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("reset_mem_rreq", 32'(mem_rrequest), 32'd0);
        chk("reset_mem_wreq", 32'(mem_wrequest), 32'd0);
        chk("reset_ibus_rdata", ibus_rdata, 32'h0);
        chk("reset_dbus_rdata", dbus_rdata, 32'h0);

        // Lone fetch with single-cycle memory; next fetch issued in the release cycle
        @(negedge clock);
        reset_n = 1'b1;
        ibus_rrequest = 1'b1;
        ibus_address = 32'h100;
        #1;
        chk("s1_issue_addr", mem_address, 32'h100);
        chk("s1_issue_rreq", 32'(mem_rrequest), 32'd1);
        chk("s1_no_resp", 32'(ibus_rresponse), 32'd0);
        @(negedge clock);
        ibus_address = 32'h104;
        r1 = 1'b1;
        mem_rdata = 32'h13;
        #1;
        chk("s1_resp", 32'(ibus_rresponse), 32'd1);
        chk("s1_rdata", ibus_rdata, 32'h13);
        chk("s1_next_addr", mem_address, 32'h104);
        chk("s1_next_rreq", 32'(mem_rrequest), 32'd1);
        @(negedge clock);
        ibus_rrequest = 1'b0;
        mem_rdata = 32'h17;
        #1;
        chk("s1_resp2", 32'(ibus_rresponse), 32'd1);
        chk("s1_rdata2", ibus_rdata, 32'h17);
        chk("s1_empty_rreq", 32'(mem_rrequest), 32'd0);
        @(negedge clock);
        r1 = 1'b0;
        mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("s1_quiet_resp", 32'(ibus_rresponse), 32'd0);
        chk("s1_hold_rdata", ibus_rdata, 32'h17);

        // Simultaneous load and fetch, data bus first
        @(negedge clock);
        dbus_rrequest = 1'b1;
        dbus_address = 32'h2000;
        ibus_rrequest = 1'b1;
        ibus_address = 32'h104;
        #1;
        chk("s2_c0_addr", mem_address, 32'h2000);
        chk("s2_c0_rreq", 32'(mem_rrequest), 32'd1);
        chk("s2_c0_wreq", 32'(mem_wrequest), 32'd0);
        @(negedge clock);
        r1 = 1'b1;
        mem_rdata = 32'hCAFE_BABE;
        #1;
        chk("s2_c1_dresp", 32'(dbus_rresponse), 32'd0);
        chk("s2_c1_iresp", 32'(ibus_rresponse), 32'd0);
        chk("s2_c1_addr", mem_address, 32'h104);
        chk("s2_c1_rreq", 32'(mem_rrequest), 32'd1);
        @(negedge clock);
        mem_rdata = 32'h93;
        dbus_rrequest = 1'b0;
        ibus_rrequest = 1'b0;
        #1;
        chk("s2_c2_dresp", 32'(dbus_rresponse), 32'd1);
        chk("s2_c2_drdata", dbus_rdata, 32'hCAFE_BABE);
        chk("s2_c2_iresp", 32'(ibus_rresponse), 32'd1);
        chk("s2_c2_irdata", ibus_rdata, 32'h93);
        chk("s2_c2_empty", 32'(mem_rrequest), 32'd0);
        @(negedge clock);
        r1 = 1'b0;
        mem_rdata = 32'h0;
        #1;
        chk("s2_hold_drdata", dbus_rdata, 32'hCAFE_BABE);
        chk("s2_quiet_dresp", 32'(dbus_rresponse), 32'd0);

        // Store with wait cycles; core-side inputs change but mem side stays on captured values
        @(negedge clock);
        dbus_wrequest = 1'b1;
        dbus_address = 32'h3000;
        dbus_wdata = 32'h1122_3344;
        dbus_wstrobe = 4'b0011;
        #1;
        chk("s3_c0_wreq", 32'(mem_wrequest), 32'd1);
        chk("s3_c0_rreq", 32'(mem_rrequest), 32'd0);
        chk("s3_c0_wdata", mem_wdata, 32'h1122_3344);
        chk("s3_c0_strobe", 32'(mem_wstrobe), 32'h3);
        for (int c = 1; c < 3; c++) begin
            @(negedge clock);
            dbus_address = 32'h5555_0000;
            dbus_wdata = 32'hDEAD_BEEF;
            dbus_wstrobe = 4'b1100;
            r1 = (c == 2);
            #1;
            chk("s3_wait_addr", mem_address, 32'h3000);
            chk("s3_wait_wdata", mem_wdata, 32'h1122_3344);
            chk("s3_wait_strobe", 32'(mem_wstrobe), 32'h3);
            chk("s3_wait_wreq", 32'(mem_wrequest), 32'd1);
            chk("s3_wait_wresp", 32'(dbus_wresponse), 32'd0);
        end
        @(negedge clock);
        r1 = 1'b0;
        w1 = 1'b1;
        dbus_wrequest = 1'b0;
        #1;
        chk("s3_wresp", 32'(dbus_wresponse), 32'd1);
        chk("s3_no_rresp", 32'(dbus_rresponse), 32'd0);
        chk("s3_empty_wreq", 32'(mem_wrequest), 32'd0);
        @(negedge clock);
        w1 = 1'b0;
        #1;
        chk("s3_wresp_drop", 32'(dbus_wresponse), 32'd0);

        // Mismatched responses, held duplicate fetch, then reset during SERVE_SECOND
        @(negedge clock);
        dbus_rrequest = 1'b1;
        dbus_address = 32'h2400;
        ibus_rrequest = 1'b1;
        ibus_address = 32'h200;
        #1;
        chk("s5_c0_addr", mem_address, 32'h2400);
        @(negedge clock);
        w1 = 1'b1;
        #1;
        chk("s5_mismatch_dresp", 32'(dbus_rresponse), 32'd0);
        chk("s5_mismatch_addr", mem_address, 32'h2400);
        @(negedge clock);
        w1 = 1'b0;
        r1 = 1'b1;
        mem_rdata = 32'h55;
        #1;
        chk("s5_second_addr", mem_address, 32'h200);
        chk("s5_second_iresp", 32'(ibus_rresponse), 32'd0);
        @(negedge clock);
        r1 = 1'b0;
        #1;
        chk("s5_held_addr", mem_address, 32'h200);
        chk("s5_held_rreq", 32'(mem_rrequest), 32'd1);
        chk("s5_held_iresp", 32'(ibus_rresponse), 32'd0);
        @(negedge clock);
        w1 = 1'b1;
        #1;
        chk("s5_mismatch2_iresp", 32'(ibus_rresponse), 32'd0);
        chk("s5_mismatch2_dresp", 32'(dbus_rresponse), 32'd0);
        @(negedge clock);
        w1 = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        quiet();
        r1 = 1'b1;
        mem_rdata = 32'h77;
        #1;
        chk("s6_late_iresp", 32'(ibus_rresponse), 32'd0);
        chk("s6_late_dresp", 32'(dbus_rresponse), 32'd0);
        chk("s6_ibus_rdata", ibus_rdata, 32'h0);
        chk("s6_dbus_rdata", dbus_rdata, 32'h0);
        chk("s6_mem_rreq", 32'(mem_rrequest), 32'd0);
        @(negedge clock);
        r1 = 1'b0;
        ibus_rrequest = 1'b1;
        ibus_address = 32'h300;
        #1;
        chk("s6_idle_addr", mem_address, 32'h300);
        chk("s6_idle_rreq", 32'(mem_rrequest), 32'd1);
        @(negedge clock);
        r1 = 1'b1;
        mem_rdata = 32'h99;
        ibus_rrequest = 1'b0;
        #1;
        chk("s6_resp", 32'(ibus_rresponse), 32'd1);
        chk("s6_rdata", ibus_rdata, 32'h99);

        // Instruction-first instance: simultaneous store and fetch
        @(negedge clock);
        quiet();
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        dbus_wrequest = 1'b1;
        dbus_address = 32'h3000;
        dbus_wdata = 32'h1122_3344;
        dbus_wstrobe = 4'b0011;
        ibus_rrequest = 1'b1;
        ibus_address = 32'h104;
        #1;
        chk("s4_c0_addr", mem_address_b, 32'h104);
        chk("s4_c0_rreq", 32'(mem_rrequest_b), 32'd1);
        chk("s4_c0_wreq", 32'(mem_wrequest_b), 32'd0);
        @(negedge clock);
        r0 = 1'b1;
        mem_rdata = 32'h13;
        #1;
        chk("s4_c1_iresp", 32'(ibus_rresponse_b), 32'd0);
        chk("s4_c1_addr", mem_address_b, 32'h3000);
        chk("s4_c1_wreq", 32'(mem_wrequest_b), 32'd1);
        chk("s4_c1_wdata", mem_wdata_b, 32'h1122_3344);
        @(negedge clock);
        r0 = 1'b0;
        mem_rdata = 32'hAAAA_AAAA;
        #1;
        chk("s4_c2_strobe", 32'(mem_wstrobe_b), 32'h3);
        chk("s4_c2_wresp", 32'(dbus_wresponse_b), 32'd0);
        @(negedge clock);
        w0 = 1'b1;
        ibus_rrequest = 1'b0;
        dbus_wrequest = 1'b0;
        #1;
        chk("s4_c3_iresp", 32'(ibus_rresponse_b), 32'd1);
        chk("s4_c3_irdata", ibus_rdata_b, 32'h13);
        chk("s4_c3_wresp", 32'(dbus_wresponse_b), 32'd1);
        chk("s4_c3_empty", 32'(mem_wrequest_b), 32'd0);
        @(negedge clock);
        w0 = 1'b0;
        #1;
        chk("s4_c4_iresp", 32'(ibus_rresponse_b), 32'd0);
        chk("s4_c4_wresp", 32'(dbus_wresponse_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
